// File: rtl/uart_pkg.sv
// Shared definitions for the 7-bit UART receiver: receiver states, frame
// geometry, parity-mode encoding and small bit-level helper functions.
package uart_pkg;

  // Receiver sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  // Data bits per frame and oversampling ticks per bit
  localparam int DATA_W = 7;
  localparam int OVS    = 16;

  // Parity-mode encoding as seen on p_sel
  localparam logic PAR_EVEN = 1'b1;
  localparam logic PAR_ODD  = 1'b0;

  // Two-of-three vote used to filter each bit against line noise
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity check over data plus received parity bit; returns 1 on mismatch
  function automatic logic parity_err(input logic [DATA_W-1:0] data,
                                      input logic              par_bit,
                                      input logic              mode);
    logic x;
    x = ^{data, par_bit};
    case (mode)
      PAR_EVEN: parity_err = x;
      PAR_ODD:  parity_err = ~x;
      default:  parity_err = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: counts 0..DIV-1 and emits a one-cycle tick
// on each wrap. A synchronous clear restarts the count so the tick grid can
// be re-aligned to an incoming start edge.
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int               CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;
  logic             tick_d;

  // Next count and tick: clear wins, otherwise wrap at DIV-1
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (clr) begin
      cnt_d  = '0;
      tick_d = 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + CNT_ONE;
      tick_d = 1'b0;
    end
  end

  // Divider state and registered tick output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, 7 data bits LSB first, one parity bit (even or
// odd, chosen per frame by p_sel) and one stop bit. The line is synchronised,
// oversampled OVS times per bit, and each bit is a 2-of-3 vote taken around
// the middle of the bit. Results are published with a one-cycle data_valid.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = uart_pkg::OVS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       p_sel,
  output logic [6:0] data_out,
  output logic       data_valid,
  output logic       p_err,
  output logic       f_err,
  output logic       busy
);

  import uart_pkg::*;

  localparam int DIV  = CLK_FREQ / (BAUD * OVS);
  localparam int PH_W = $clog2(OVS);

  // Bit-phase landmarks: two early votes, the evaluating vote, end of bit
  localparam logic [PH_W-1:0] PH_ZERO = PH_W'(0);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_S0   = PH_W'(OVS / 2 - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(OVS / 2);
  localparam logic [PH_W-1:0] PH_EVAL = PH_W'(OVS / 2 + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
  localparam logic [2:0]      BIT_LAST = 3'(DATA_W - 1);

  // Synchroniser and edge detection
  logic       sync1_q;
  logic       sync2_q;
  logic       rx_prev_q;
  logic [2:0] settle_q;
  logic       rx_s;
  logic       start_edge;

  // Timing
  logic            tick;
  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;
  logic            at_eval;
  logic            at_last;

  // Bit sampling
  logic samp_a_q;
  logic samp_b_q;
  logic bit_val;

  // Frame sequencer
  state_t            state_q;
  logic [2:0]        bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_q;
  logic              p_sel_q;

  // Published results
  logic [DATA_W-1:0] data_out_q;
  logic              data_valid_q;
  logic              p_err_q;
  logic              f_err_q;
  logic              busy_q;

  // Two-flop synchroniser; settle_q marks when rx_s and rx_prev_q carry real
  // line samples so a line held low across reset is not seen as an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      settle_q  <= 3'b000;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
      settle_q  <= {settle_q[1:0], 1'b1};
    end
  end

  assign rx_s       = sync2_q;
  assign start_edge = (state_q == ST_IDLE) && settle_q[2] && rx_prev_q && !rx_s;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_edge),
    .tick (tick)
  );

  // Phase counter successor, wrapping at the end of the bit
  always_comb begin
    phase_d = phase_q;
    if (phase_q == PH_LAST) begin
      phase_d = PH_ZERO;
    end else begin
      phase_d = phase_q + PH_ONE;
    end
  end

  assign at_eval = tick && (phase_q == PH_EVAL);
  assign at_last = tick && (phase_q == PH_LAST);
  assign bit_val = maj3(samp_a_q, samp_b_q, rx_s);

  // Capture the two early votes of each bit; the third is rx_s at evaluation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else if (tick && (phase_q == PH_S0)) begin
      samp_a_q <= rx_s;
    end else if (tick && (phase_q == PH_S1)) begin
      samp_b_q <= rx_s;
    end
  end

  // Frame sequencer: walks the frame, assembles data and publishes results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_ZERO;
      bit_cnt_q    <= 3'd0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      p_sel_q      <= PAR_ODD;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      p_err_q      <= 1'b0;
      f_err_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          phase_q   <= PH_ZERO;
          bit_cnt_q <= 3'd0;
          if (start_edge) begin
            state_q <= ST_START;
            busy_q  <= 1'b1;
            p_sel_q <= p_sel;
          end
        end
        ST_START: begin
          if (tick) begin
            phase_q <= phase_d;
          end
          if (at_eval && bit_val) begin
            // Start bit did not hold low: treat as noise, publish nothing
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (at_last) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            phase_q <= phase_d;
          end
          if (at_eval) begin
            shift_q <= {bit_val, shift_q[DATA_W-1:1]};
          end
          if (at_last) begin
            if (bit_cnt_q == BIT_LAST) begin
              state_q   <= ST_PARITY;
              bit_cnt_q <= 3'd0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            phase_q <= phase_d;
          end
          if (at_eval) begin
            par_q <= bit_val;
          end
          if (at_last) begin
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (tick) begin
            phase_q <= phase_d;
          end
          if (at_eval) begin
            data_out_q   <= shift_q;
            p_err_q      <= parity_err(shift_q, par_q, p_sel_q);
            f_err_q      <= ~bit_val;
            data_valid_q <= 1'b1;
            if (bit_val) begin
              // Leave early so a start edge right after the stop bit is seen
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          // A low line here is a break, never a new start bit
          if (rx_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign p_err      = p_err_q;
  assign f_err      = f_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Frames are driven bit by bit on rx and
// every published result is compared against a frame-level model computed
// from the data, parity bit, stop bit and parity mode that were sent.
module tb_uart_rx;

  localparam int TB_CLK_FREQ = 640_000;
  localparam int TB_BAUD     = 10_000;
  localparam int TB_OVS      = 16;
  localparam int BIT_CLK     = TB_CLK_FREQ / TB_BAUD;  // clocks per bit

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       p_sel;
  logic [6:0] data_out;
  logic       data_valid;
  logic       p_err;
  logic       f_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int dv_count = 0;
  logic dv_prev = 1'b0;
  logic [8:0] obs_q[$];       // {data_out, p_err, f_err} at each data_valid
  logic [8:0] last_exp = 9'd0; // outputs the design should currently hold

  uart_rx #(
    .CLK_FREQ (TB_CLK_FREQ),
    .BAUD     (TB_BAUD),
    .OVS      (TB_OVS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .p_sel      (p_sel),
    .data_out   (data_out),
    .data_valid (data_valid),
    .p_err      (p_err),
    .f_err      (f_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Record every published result and flag back-to-back valid pulses
  always @(negedge clk) begin
    if (data_valid) begin
      n_checks++;
      if (dv_prev) begin
        n_fail++;
        $display("FAIL dv_single_cycle: data_valid=1 on two consecutive cycles, required one-cycle pulse");
      end
      obs_q.push_back({data_out, p_err, f_err});
      dv_count++;
    end
    dv_prev = data_valid;
  end

  // Frame-level reference: parity over data+parity bit, stop bit low => framing error
  function automatic logic [8:0] model_frame(input logic [6:0] d, input logic par,
                                             input logic stop, input logic even);
    int   ones;
    logic perr;
    ones = $countones(d) + int'(par);
    if (even) perr = (ones % 2) != 0;
    else      perr = (ones % 2) == 0;
    return {d, perr, ~stop};
  endfunction

  task automatic send_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [6:0] d, input logic par, input logic stop);
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 7; i++) send_bit(d[i], BIT_CLK);
    send_bit(par, BIT_CLK);
    send_bit(stop, BIT_CLK);
  endtask

  task automatic test_reset();
    int busy_seen;
    rst = 1'b1; rx = 1'b0; p_sel = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({data_out, data_valid, p_err, f_err, busy} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required all zero", {data_out, data_valid, p_err, f_err, busy});
    end
    // Line already low when reset drops must not start a frame
    rst = 1'b0;
    busy_seen = 0;
    for (int i = 0; i < 2 * BIT_CLK; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    n_checks++;
    if (busy_seen != 0 || dv_count != 0) begin
      n_fail++;
      $display("FAIL low_after_reset: busy cycles %0d, data_valid count %0d, required 0 and 0", busy_seen, dv_count);
    end
    send_bit(1'b1, BIT_CLK);
  endtask

  task automatic test_even_parity();
    logic [8:0] got;
    obs_q.delete();
    p_sel = 1'b1;
    send_frame(7'h55, 1'b0, 1'b1);
    send_bit(1'b1, BIT_CLK);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL even_count: %0d data_valid pulses, required 1", obs_q.size());
    end else begin
      got = obs_q.pop_front();
      n_checks++;
      if (got !== {7'h55, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL even_result: got data %h p %b f %b, required 55 0 0", got[8:2], got[1], got[0]);
      end
    end
    last_exp = {7'h55, 1'b0, 1'b0};
  endtask

  task automatic test_odd_parity();
    logic [8:0] got;
    logic [8:0] exp;
    obs_q.delete();
    p_sel = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp = model_frame(7'h55, k[0], 1'b1, 1'b0);
      send_frame(7'h55, k[0], 1'b1);
      send_bit(1'b1, BIT_CLK);
      n_checks++;
      if (obs_q.size() != 1) begin
        n_fail++;
        $display("FAIL odd_count_%0d: %0d data_valid pulses, required 1", k, obs_q.size());
        obs_q.delete();
      end else begin
        got = obs_q.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL odd_result_%0d: got data %h p %b, required data %h p %b", k, got[8:2], got[1], exp[8:2], exp[1]);
        end
      end
      last_exp = exp;
    end
  endtask

  task automatic test_glitch();
    int   dv_before;
    int   glitch;
    dv_before = dv_count;
    glitch = (BIT_CLK * 3) / 10;
    send_bit(1'b0, glitch);
    send_bit(1'b1, BIT_CLK - glitch);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_busy: busy=%b one bit after glitch, required 0", busy);
    end
    send_bit(1'b1, BIT_CLK);
    n_checks++;
    if (dv_count != dv_before || {data_out, p_err, f_err} !== last_exp) begin
      n_fail++;
      $display("FAIL glitch_outputs: pulses %0d->%0d, outputs %h, required no pulse and %h",
               dv_before, dv_count, {data_out, p_err, f_err}, last_exp);
    end
  endtask

  task automatic test_break();
    logic [8:0] got;
    logic [8:0] exp;
    logic       par;
    obs_q.delete();
    p_sel = 1'($urandom_range(0, 1));
    par   = 1'($urandom_range(0, 1));
    exp   = model_frame(7'h3A, par, 1'b0, p_sel);
    send_frame(7'h3A, par, 1'b0);
    send_bit(1'b0, 3 * BIT_CLK);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL break_hold: busy=%b while line held low, required 1", busy);
    end
    send_bit(1'b1, 3 * BIT_CLK);
    n_checks++;
    if (obs_q.size() != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL break_count: %0d pulses busy=%b, required 1 pulse busy=0", obs_q.size(), busy);
      obs_q.delete();
    end else begin
      got = obs_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL break_result: got %h, required %h (f_err 1)", got, exp);
      end
    end
    last_exp = exp;
  endtask

  task automatic test_back_to_back();
    logic [6:0] d [2];
    logic [8:0] exp [2];
    logic [8:0] got;
    logic       par;
    obs_q.delete();
    d[0] = 7'h01; d[1] = 7'h7F;
    p_sel = 1'($urandom_range(0, 1));
    for (int k = 0; k < 2; k++) begin
      par = 1'($urandom_range(0, 1));
      exp[k] = model_frame(d[k], par, 1'b1, p_sel);
      send_frame(d[k], par, 1'b1);
    end
    send_bit(1'b1, 2 * BIT_CLK);
    n_checks++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: %0d pulses, required 2", obs_q.size());
      obs_q.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        got = obs_q.pop_front();
        n_checks++;
        if (got !== exp[k]) begin
          n_fail++;
          $display("FAIL b2b_frame_%0d: got %h, required %h", k, got, exp[k]);
        end
      end
    end
    last_exp = exp[1];
  endtask

  task automatic test_reset_mid();
    logic [6:0] d;
    logic [8:0] got;
    logic [8:0] exp;
    int         dv_before;
    obs_q.delete();
    p_sel = 1'b1;
    d = 7'h4B;
    dv_before = dv_count;
    send_bit(1'b0, BIT_CLK);
    for (int i = 0; i < 3; i++) send_bit(d[i], BIT_CLK);
    send_bit(d[3], BIT_CLK / 2);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({data_out, data_valid, p_err, f_err, busy} !== 11'd0) begin
      n_fail++;
      $display("FAIL midframe_reset: got %b, required all zero", {data_out, data_valid, p_err, f_err, busy});
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send_bit(1'b1, 2 * BIT_CLK);
    n_checks++;
    if (dv_count != dv_before) begin
      n_fail++;
      $display("FAIL midframe_no_valid: %0d pulses after abort, required 0", dv_count - dv_before);
    end
    exp = model_frame(7'h2C, 1'b1, 1'b1, 1'b1);
    send_frame(7'h2C, 1'b1, 1'b1);
    send_bit(1'b1, BIT_CLK);
    n_checks++;
    if (obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL post_reset_count: %0d pulses, required 1", obs_q.size());
      obs_q.delete();
    end else begin
      got = obs_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL post_reset_frame: got %h, required %h", got, exp);
      end
    end
    last_exp = exp;
  endtask

  task automatic test_random();
    logic [8:0] exp_q[$];
    logic [8:0] exp;
    logic [8:0] got;
    logic [6:0] d;
    logic       par;
    logic       stop;
    obs_q.delete();
    for (int k = 0; k < 8; k++) begin
      p_sel = 1'($urandom_range(0, 1));
      d     = 7'($urandom_range(0, 127));
      par   = 1'($urandom_range(0, 1));
      stop  = 1'b1;
      exp_q.push_back(model_frame(d, par, stop, p_sel));
      send_frame(d, par, stop);
      send_bit(1'b1, BIT_CLK * int'($urandom_range(0, 2)));
    end
    send_bit(1'b1, 2 * BIT_CLK);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL random_count: %0d pulses, required %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        got = obs_q.pop_front();
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL random_frame_%0d: got %h, required %h", k, got, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
